// File: rtl/tt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_arb_pkg
// Purpose  : Shared definitions for the tile output arbiters: FSM state
//            encoding, default sizes and the rotate-and-priority-encode
//            helper used by the round-robin picker.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tt_arb_pkg;

    // Default sizing for the uo_out arbiter.
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int HOLD_W_DEF  = 4;

    // Pickers are sized for the largest supported requester count so that
    // index and pointer buses keep one fixed width across all tile arbiters.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Returns {found, index} of the first set request at or above ptr,
    // wrapping modulo n. Only the low n request bits take part; ptr must be
    // below n, which keeps ptr+k below 2n so a single subtract wraps it.
    function automatic logic [IDX_W:0] rr_first(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((k < n) && !found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage : tt_arb_pkg
`default_nettype wire

// File: rtl/tt_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_out_arbiter_if
// Purpose  : Request/grant bundle between the user-logic requesters and the
//            uo_out arbiter.
// Ports    : req       - per-requester level request
//            req_data  - requester i data in [i*DATA_W +: DATA_W]
//            hold_len  - maximum tenure in cycles (0 behaves as 1)
//            gnt       - registered one-hot grant
//            out_data  - registered bus value for uo_out
//            out_valid - a grant is active
//            busy      - arbiter is in GRANT or GAP
//            modport master : requester side, modport slave : arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface tt_out_arbiter_if
    import tt_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HOLD_W  = HOLD_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [HOLD_W-1:0]         hold_len;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      busy;

    modport master (
        output req,
        output req_data,
        output hold_len,
        input  gnt,
        input  out_data,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  hold_len,
        output gnt,
        output out_data,
        output out_valid,
        output busy
    );

endinterface : tt_out_arbiter_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority picker. Finds the first set
//            request searching upward from rr_ptr, wrapping at NUM_REQ.
// Ports    : req    (in)  - request vector, NUM_REQ bits
//            rr_ptr (in)  - highest-priority index this round (< NUM_REQ)
//            any    (out) - at least one request is set
//            idx    (out) - index of the selected requester (valid if any)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import tt_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] w_req_pad;
    logic [IDX_W:0]     w_pick;

    always_comb begin
        w_req_pad                = '0;
        w_req_pad[NUM_REQ-1:0]   = req;
    end

    assign w_pick = rr_first(w_req_pad, rr_ptr, NUM_REQ);
    assign any    = w_pick[IDX_W];
    assign idx    = w_pick[IDX_W-1:0];

endmodule : rr_pick
`default_nettype wire

// File: rtl/tt_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tt_out_arbiter
// Purpose  : Round-robin arbiter sharing the tile's dedicated output bus
//            (uo_out) between NUM_REQ requesters. The winner owns the bus for
//            at most hold_len cycles (0 behaves as 1) or until it drops req,
//            with an optional one-cycle GAP between owners. All outputs are
//            registered; reset is asynchronous and active-high.
// Ports    : clk - clock
//            rst - asynchronous active-high reset
//            bus - tt_out_arbiter_if.slave (req, req_data, hold_len in;
//                  gnt, out_data, out_valid, busy out)
// Revision : 1.0 - initial release
// ============================================================================
module tt_out_arbiter
    import tt_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int HOLD_W  = HOLD_W_DEF,
    parameter bit GAP_EN  = 1'b1
) (
    input logic              clk,
    input logic              rst,
    tt_out_arbiter_if.slave  bus
);

    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_ONE = HOLD_W'(1);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_winner;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_busy;

    logic                w_any;
    logic [IDX_W-1:0]    w_idx;
    logic [NUM_REQ-1:0]  w_pick_gnt;
    logic [DATA_W-1:0]   w_pick_data;
    logic                w_win_req;
    logic [DATA_W-1:0]   w_win_data;
    logic [HOLD_W-1:0]   w_hold_init;
    logic [IDX_W-1:0]    w_next_ptr;
    logic                w_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .idx    (w_idx)
    );

    // Decode the freshly picked requester (used at the grant edge) and the
    // current owner (used every GRANT cycle) without variable part-selects,
    // so an index above NUM_REQ-1 can never select out of range.
    always_comb begin
        w_pick_gnt  = '0;
        w_pick_data = '0;
        w_win_req   = 1'b0;
        w_win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_pick_gnt[i] = 1'b1;
                w_pick_data   = bus.req_data[i*DATA_W +: DATA_W];
            end
            if (r_winner == IDX_W'(i)) begin
                w_win_req  = bus.req[i];
                w_win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_hold_init = (bus.hold_len == '0) ? c_HOLD_ONE : bus.hold_len;
    assign w_next_ptr  = (r_winner == c_LAST_IDX) ? '0 : r_winner + 1'b1;

    // Release and timeout lead to the same end-of-tenure action.
    assign w_end = !w_win_req || (r_hold_cnt == c_HOLD_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_winner    <= w_idx;
                        r_hold_cnt  <= w_hold_init;
                        r_gnt       <= w_pick_gnt;
                        // Load the winner's data at the grant edge so the
                        // bus carries valid data in every valid cycle.
                        r_out_data  <= w_pick_data;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                GRANT: begin
                    if (w_end) begin
                        r_state     <= GAP_EN ? GAP : IDLE;
                        r_rr_ptr    <= w_next_ptr;
                        r_gnt       <= '0;
                        r_out_data  <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= GAP_EN;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt - 1'b1;
                        r_out_data  <= w_win_data;
                    end
                end

                GAP: begin
                    // Requests are ignored here; arbitration restarts in IDLE.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= '0;
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule : tt_out_arbiter
`default_nettype wire

// File: tb/tb_tt_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_out_arbiter
// Purpose  : Self-checking bench for tt_out_arbiter. Two instances are used:
//            one with GAP_EN=1 and one with GAP_EN=0. Each vector gives the
//            inputs for one clock and the outputs expected after that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_out_arbiter;

    localparam int c_NR = 4;
    localparam int c_DW = 8;
    localparam int c_HW = 4;

    logic clk;
    logic rst;

    typedef struct {
        string      name;
        bit         sel0;   // 1: drive/check the GAP_EN=0 instance
        logic [3:0] req;
        logic [3:0] hold;
        logic [7:0] d1;     // data of requester 1 (others are fixed)
        logic [3:0] e_gnt;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
    } vec_t;

    typedef struct {
        string      name;
        bit         sel0;
        logic [3:0] gnt;
        logic       valid;
        logic [7:0] data;
        logic       busy;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   mark_rst;

    tt_out_arbiter_if #(.NUM_REQ(c_NR), .DATA_W(c_DW), .HOLD_W(c_HW)) bus1 ();
    tt_out_arbiter_if #(.NUM_REQ(c_NR), .DATA_W(c_DW), .HOLD_W(c_HW)) bus0 ();

    tt_out_arbiter #(
        .NUM_REQ (c_NR), .DATA_W (c_DW), .HOLD_W (c_HW), .GAP_EN (1'b1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    tt_out_arbiter #(
        .NUM_REQ (c_NR), .DATA_W (c_DW), .HOLD_W (c_HW), .GAP_EN (1'b0)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    function automatic void add(string n, bit s0, logic [3:0] r, logic [3:0] h,
                                logic [7:0] d1, logic [3:0] g, logic v,
                                logic [7:0] d, logic b);
        vec_t x;
        x.name = n; x.sel0 = s0; x.req = r; x.hold = h; x.d1 = d1;
        x.e_gnt = g; x.e_valid = v; x.e_data = d; x.e_busy = b;
        vt.push_back(x);
    endfunction

    task automatic check_out(input exp_t e);
        logic [3:0] g;
        logic       v;
        logic [7:0] d;
        logic       b;
        if (e.sel0) begin
            g = bus0.gnt; v = bus0.out_valid; d = bus0.out_data; b = bus0.busy;
        end else begin
            g = bus1.gnt; v = bus1.out_valid; d = bus1.out_data; b = bus1.busy;
        end
        n_vec++;
        if (g !== e.gnt || v !== e.valid || d !== e.data || b !== e.busy) begin
            n_err++;
            $display("FAIL %s: got gnt=%b valid=%b data=%h busy=%b, want gnt=%b valid=%b data=%h busy=%b",
                     e.name, g, v, d, b, e.gnt, e.valid, e.data, e.busy);
        end
        // Structural invariants: grant zero or one-hot, data zero when idle.
        n_vec++;
        if (!$onehot0(g) || (!v && d !== 8'h00)) begin
            n_err++;
            $display("FAIL %s_inv: got gnt=%b valid=%b data=%h, want onehot0 gnt and zero data when not valid",
                     e.name, g, v, d);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        if (v.sel0) begin
            bus0.req      = v.req;
            bus0.hold_len = v.hold;
            bus0.req_data = {8'h44, 8'h33, v.d1, 8'h11};
            bus1.req      = '0;
        end else begin
            bus1.req      = v.req;
            bus1.hold_len = v.hold;
            bus1.req_data = {8'h44, 8'h33, v.d1, 8'h11};
            bus0.req      = '0;
        end
        e.name = v.name; e.sel0 = v.sel0; e.gnt = v.e_gnt;
        e.valid = v.e_valid; e.data = v.e_data; e.busy = v.e_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: got empty scoreboard, want one entry", v.name);
        end else begin
            check_out(sb.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        n_vec = 0;
        n_err = 0;

        // ---- vector table (inputs for one clock -> outputs after the edge)
        //   name   s0  req      hold d1     gnt      v  data   busy
        // single requester, timeout after 3 cycles, GAP then re-grant
        add("A1", 0, 4'b0010, 4'd3, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("A2", 0, 4'b0010, 4'd3, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("A3", 0, 4'b0010, 4'd3, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("A4", 0, 4'b0010, 4'd3, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("A5", 0, 4'b0010, 4'd3, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("A6", 0, 4'b0010, 4'd3, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("A7", 0, 4'b0000, 4'd3, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("A8", 0, 4'b0000, 4'd3, 8'hA5, 4'b0000, 0, 8'h00, 0);
        // requester 0 granted just before the asynchronous reset
        add("R1", 0, 4'b0001, 4'd15, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("R2", 0, 4'b0001, 4'd15, 8'hA5, 4'b0001, 1, 8'h11, 1);
        mark_rst = vt.size();
        // round-robin, all requesting, 2-cycle tenure, order 0,1,2,3,0
        add("B0a", 0, 4'b1111, 4'd2, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("B0b", 0, 4'b1111, 4'd2, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("B0g", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("B0i", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("B1a", 0, 4'b1111, 4'd2, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("B1b", 0, 4'b1111, 4'd2, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("B1g", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("B1i", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("B2a", 0, 4'b1111, 4'd2, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("B2b", 0, 4'b1111, 4'd2, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("B2g", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("B2i", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("B3a", 0, 4'b1111, 4'd2, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("B3b", 0, 4'b1111, 4'd2, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("B3g", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("B3i", 0, 4'b1111, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("B4a", 0, 4'b1111, 4'd2, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("B4b", 0, 4'b1111, 4'd2, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("B4g", 0, 4'b0000, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("B4i", 0, 4'b0000, 4'd2, 8'hA5, 4'b0000, 0, 8'h00, 0);
        // early release after 4 granted cycles with hold_len=15
        add("C1", 0, 4'b0100, 4'd15, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("C2", 0, 4'b0100, 4'd15, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("C3", 0, 4'b0100, 4'd15, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("C4", 0, 4'b0100, 4'd15, 8'hA5, 4'b0100, 1, 8'h33, 1);
        add("C5", 0, 4'b0000, 4'd15, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("C6", 0, 4'b0000, 4'd15, 8'hA5, 4'b0000, 0, 8'h00, 0);
        // hold_len=0 gives 1 cycle; req during GAP ignored; hold change mid-grant
        add("D1", 0, 4'b1000, 4'd0, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("D2", 0, 4'b1000, 4'd0, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("D3", 0, 4'b1000, 4'd3, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("D4", 0, 4'b1000, 4'd3, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("D5", 0, 4'b1000, 4'd9, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("D6", 0, 4'b1000, 4'd9, 8'hA5, 4'b1000, 1, 8'h44, 1);
        add("D7", 0, 4'b1000, 4'd9, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("D8", 0, 4'b0000, 4'd9, 8'hA5, 4'b0000, 0, 8'h00, 0);
        // data follows the owner's input one cycle later
        add("E1", 0, 4'b0010, 4'd4, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("E2", 0, 4'b0010, 4'd4, 8'h5A, 4'b0010, 1, 8'h5A, 1);
        add("E3", 0, 4'b0010, 4'd4, 8'hC3, 4'b0010, 1, 8'hC3, 1);
        add("E4", 0, 4'b0000, 4'd4, 8'hC3, 4'b0000, 0, 8'h00, 1);
        add("E5", 0, 4'b0000, 4'd4, 8'hC3, 4'b0000, 0, 8'h00, 0);
        // winner drops req in its first granted cycle -> 1-cycle tenure
        add("F1", 0, 4'b0001, 4'd5, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("F2", 0, 4'b0000, 4'd5, 8'hA5, 4'b0000, 0, 8'h00, 1);
        add("F3", 0, 4'b0000, 4'd5, 8'hA5, 4'b0000, 0, 8'h00, 0);
        // GAP_EN=0: valid(0), idle, valid(1), idle, valid(0)
        add("G1", 1, 4'b0011, 4'd1, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("G2", 1, 4'b0011, 4'd1, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("G3", 1, 4'b0011, 4'd1, 8'hA5, 4'b0010, 1, 8'hA5, 1);
        add("G4", 1, 4'b0011, 4'd1, 8'hA5, 4'b0000, 0, 8'h00, 0);
        add("G5", 1, 4'b0011, 4'd1, 8'hA5, 4'b0001, 1, 8'h11, 1);
        add("G6", 1, 4'b0000, 4'd1, 8'hA5, 4'b0000, 0, 8'h00, 0);

        // ---- reset state
        bus1.req = '0; bus1.hold_len = '0; bus1.req_data = '0;
        bus0.req = '0; bus0.hold_len = '0; bus0.req_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        z.name = "reset1"; z.sel0 = 1'b0; z.gnt = '0; z.valid = 1'b0; z.data = '0; z.busy = 1'b0;
        check_out(z);
        z.name = "reset0"; z.sel0 = 1'b1;
        check_out(z);
        rst = 1'b0;

        for (int i = 0; i < mark_rst; i++) begin
            step(vt[i]);
        end

        // ---- asynchronous reset mid-grant: outputs clear without an edge
        #3;
        rst = 1'b1;
        #1;
        z.name = "async_rst"; z.sel0 = 1'b0; z.gnt = '0; z.valid = 1'b0; z.data = '0; z.busy = 1'b0;
        check_out(z);
        bus1.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = mark_rst; i < vt.size(); i++) begin
            step(vt[i]);
        end

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d leftover entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tt_out_arbiter
`default_nettype wire
